// File: rtl/mm_ctrl_pkg.sv
// rtl/mm_ctrl_pkg.sv - shared opcodes, command field layout and FSM states for mm_sequencer
package mm_ctrl_pkg;
  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_MATMUL = 4'd1;
  localparam logic [3:0] OP_WRITE  = 4'd2;
  localparam logic [3:0] OP_CFG    = 4'd3;

  localparam int OPC_LSB  = 0;
  localparam int A_LSB    = 4;
  localparam int B_LSB    = 8;
  localparam int C_LSB    = 12;
  // page field bit that selects the W file (1) or the X file (0)
  localparam int FSEL_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [3:0] cmd_field(input logic [31:0] op, input int lsb);
    return op[lsb +: 4];
  endfunction
endpackage

// File: rtl/mm_stream_counter.sv
// rtl/mm_stream_counter.sv - nested W-cell / X-row-group counter with last detection
module mm_stream_counter #(
  parameter int IDX_W = 9,
  parameter int XR_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [IDX_W-1:0] wlen,
  input  logic [XR_W-1:0]  xlen,
  output logic [IDX_W-1:0] w_idx,
  output logic [XR_W-1:0]  x_idx,
  output logic             w_last,
  output logic             tile_end
);
  // start held high parks both indices at 0; low lets them advance every cycle
  assign w_last   = !start && (w_idx == wlen);
  assign tile_end = w_last && (x_idx == xlen);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_idx <= '0;
      x_idx <= '0;
    end else if (enable) begin
      if (start || tile_end) begin
        w_idx <= '0;
        x_idx <= '0;
      end else if (w_last) begin
        w_idx <= '0;
        x_idx <= x_idx + 1'b1;
      end else begin
        w_idx <= w_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mm_sequencer.sv
// rtl/mm_sequencer.sv - command sequencer for page writes, tile streaming and result drain
module mm_sequencer
  import mm_ctrl_pkg::*;
#(
  parameter int TILE     = 8,
  parameter int IDX_W    = 9,
  parameter int XR_W     = 3,
  parameter int PAGE_W   = 2,
  parameter int DRAIN    = 16,
  parameter int DEF_WLEN = 31,
  parameter int DEF_XLEN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_op,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  input  logic [TILE-1:0]   mult_clear_out,
  output logic              w_we,
  output logic [PAGE_W-1:0] w_wpage,
  output logic [PAGE_W-1:0] w_rpage,
  output logic [1:0]        x_we,
  output logic [PAGE_W-1:0] x_wpage,
  output logic [PAGE_W-1:0] x_rpage,
  output logic              stream_en,
  output logic [IDX_W-1:0]  w_idx,
  output logic [XR_W-1:0]   x_idx,
  output logic              w_last,
  output logic [TILE-1:0]   y_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int DC_W = $clog2(DRAIN + 1);

  state_t state, state_n;

  logic [3:0]        opc, fa, fb, fc;
  logic              accept, reject, tile_end, wr_word, bulk, streaming;
  logic              rdy_q, err_q, cfg_done_q;
  logic              lat_sel;
  logic [PAGE_W-1:0] lat_a, lat_b, lat_c;
  logic [IDX_W-1:0]  cfg_wlen, cfg_xlen, run_wlen, wcnt;
  logic [XR_W-1:0]   run_xlen;
  logic [DC_W-1:0]   dcnt;
  logic [TILE-1:0]   clr_q;
  logic              unused_bits;

  assign opc = cmd_field(cmd_op, OPC_LSB);
  assign fa  = cmd_field(cmd_op, A_LSB);
  assign fb  = cmd_field(cmd_op, B_LSB);
  assign fc  = cmd_field(cmd_op, C_LSB);

  // rdy_q keeps cmd_ready low until the first enabled edge after reset
  assign cmd_ready = enable && rdy_q && (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    reject = 1'b0;
    case (opc)
      OP_NOP, OP_WRITE: reject = 1'b0;
      OP_MATMUL: reject = fa[FSEL_BIT] || !fb[FSEL_BIT] || fc[FSEL_BIT] || (fa == fc);
      OP_CFG:    reject = (fa > 4'd1);
      default:   reject = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept && !reject) begin
          if (opc == OP_MATMUL)     state_n = S_STREAM;
          else if (opc == OP_WRITE) state_n = S_WRITE;
        end
      end
      S_WRITE:  if (in_valid && (wcnt == run_wlen)) state_n = S_DONE;
      S_STREAM: if (tile_end) state_n = S_DRAIN;
      S_DRAIN:  if (y_valid[TILE-1] || (dcnt == DC_W'(DRAIN - 1))) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       state <= S_IDLE;
    else if (enable) state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      cfg_done_q <= 1'b0;
      clr_q      <= '0;
      lat_sel    <= 1'b0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_c      <= '0;
      cfg_wlen   <= IDX_W'(DEF_WLEN);
      cfg_xlen   <= IDX_W'(DEF_XLEN);
      run_wlen   <= IDX_W'(DEF_WLEN);
      run_xlen   <= XR_W'(DEF_XLEN);
      wcnt       <= '0;
      dcnt       <= '0;
    end else if (enable) begin
      rdy_q      <= 1'b1;
      err_q      <= accept && reject;
      cfg_done_q <= accept && !reject && (opc == OP_CFG);
      clr_q      <= mult_clear_out;
      if (accept) begin
        lat_sel  <= fa[FSEL_BIT];
        lat_a    <= fa[PAGE_W-1:0];
        lat_b    <= fb[PAGE_W-1:0];
        lat_c    <= fc[PAGE_W-1:0];
        run_wlen <= cfg_wlen;
        run_xlen <= cfg_xlen[XR_W-1:0];
        wcnt     <= '0;
      end
      if (accept && !reject && (opc == OP_CFG)) begin
        if (fa[0]) cfg_xlen <= in_data[IDX_W-1:0];
        else       cfg_wlen <= in_data[IDX_W-1:0];
      end
      if (wr_word) wcnt <= wcnt + 1'b1;
      dcnt <= (state == S_DRAIN) ? dcnt + 1'b1 : '0;
    end
  end

  mm_stream_counter #(
    .IDX_W(IDX_W),
    .XR_W (XR_W)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .start   (state != S_STREAM),
    .wlen    (run_wlen),
    .xlen    (run_xlen),
    .w_idx   (w_idx),
    .x_idx   (x_idx),
    .w_last  (w_last),
    .tile_end(tile_end)
  );

  assign streaming = (state == S_STREAM);
  assign y_valid   = (streaming || state == S_DRAIN) ? clr_q : '0;
  assign bulk      = |y_valid;
  assign wr_word   = enable && (state == S_WRITE) && in_valid;

  assign stream_en = enable && streaming;
  assign busy      = (state != S_IDLE);
  assign done      = enable && ((state == S_DONE) || cfg_done_q);
  assign err       = enable && err_q;

  assign w_we    = wr_word && lat_sel;
  assign x_we    = {enable && bulk, wr_word && !lat_sel};
  assign w_wpage = ((state == S_WRITE) && lat_sel) ? lat_a : '0;
  assign x_wpage = bulk ? lat_c : (((state == S_WRITE) && !lat_sel) ? lat_a : '0);
  assign w_rpage = streaming ? lat_b : '0;
  assign x_rpage = streaming ? lat_a : '0;

  assign unused_bits = ^{cmd_op[31:16], in_data[31:IDX_W], fb[2], cfg_xlen[IDX_W-1:XR_W]};
endmodule

// File: tb/tb_mm_sequencer.sv
// tb/tb_mm_sequencer.sv - scoreboard bench for mm_sequencer
module tb_mm_sequencer;
  localparam int TILE = 8;
  localparam int K_STREAM = 0, K_XWE = 1, K_WWE = 2, K_DONE = 3, K_ERR = 4;

  logic        clk = 1'b0;
  logic        reset, enable, cmd_valid, in_valid;
  logic [31:0] cmd_op, in_data;
  logic [7:0]  mult_clear_out;
  logic        cmd_ready, w_we, stream_en, w_last, busy, done, err;
  logic [1:0]  w_wpage, w_rpage, x_we, x_wpage, x_rpage;
  logic [8:0]  w_idx;
  logic [2:0]  x_idx;
  logic [7:0]  y_valid;
  logic [36:0] outs;

  mm_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in_data(in_data), .in_valid(in_valid), .mult_clear_out(mult_clear_out),
    .w_we(w_we), .w_wpage(w_wpage), .w_rpage(w_rpage),
    .x_we(x_we), .x_wpage(x_wpage), .x_rpage(x_rpage),
    .stream_en(stream_en), .w_idx(w_idx), .x_idx(x_idx), .w_last(w_last),
    .y_valid(y_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign outs = {cmd_ready, w_we, w_wpage, w_rpage, x_we, x_wpage, x_rpage, stream_en,
                 w_idx, x_idx, w_last, y_valid, busy, done, err};

  typedef struct {int kind; logic [31:0] val;} ev_t;
  ev_t exp_q[$];
  int  total = 0, bad = 0, busy_cnt = 0, b0;

  function automatic logic [31:0] sv(int xr, int wr, int w, int x, int l);
    logic [31:0] r;
    r = 32'((xr % 4) << 13) | 32'((wr % 4) << 11) | 32'((w % 512) << 4) | 32'((x % 8) << 1) | 32'(l % 2);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push(input int k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic push_stream(input int xr, input int wr, input int wl, input int first, input int cnt);
    for (int k = first; k < first + cnt; k++)
      push(K_STREAM, sv(xr, wr, k % (wl + 1), k / (wl + 1), int'((k % (wl + 1)) == wl)));
  endtask

  task automatic observe(input int kind, input logic [31:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d val %0h want none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind_%0d", e.kind), 64'(kind), 64'(e.kind));
      check($sformatf("event_val_%0d", e.kind), 64'(val), 64'(e.val));
    end
  endtask

  always @(negedge clk) begin
    if (stream_en) observe(K_STREAM, sv(int'(x_rpage), int'(w_rpage), int'(w_idx), int'(x_idx), int'(w_last)));
    if (x_we != 2'b00) observe(K_XWE, {28'd0, x_we, x_wpage});
    if (w_we) observe(K_WWE, {30'd0, w_wpage});
    if (done) observe(K_DONE, 32'd0);
    if (err) observe(K_ERR, 32'd0);
    if (busy && enable) busy_cnt++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [31:0] data);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      step();
      t++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: cmd_ready got 0 want 1");
    end
    cmd_op    = {16'd0, c, b, a, op};
    in_data   = data;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 500) begin
      step();
      t++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic burst(input logic [4:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = pat[i];
      in_data  = 32'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run time got exceeded want finished");
    $fatal(1);
  end

  initial begin
    logic [11:0] hold;
    reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
    in_data = '0; in_valid = 1'b0; mult_clear_out = '0;
    step();
    check("reset_outputs", 64'(outs), 64'd0);
    reset = 1'b0;
    check("ready_at_release", 64'(cmd_ready), 64'd0);
    step();
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    // cfg_wlen = 3, cfg_xlen = 1
    push(K_DONE, 0); issue(4'd3, 4'd0, 4'd0, 4'd0, 32'd3);
    push(K_DONE, 0); issue(4'd3, 4'd1, 4'd0, 4'd0, 32'd1);

    push_stream(0, 0, 3, 0, 8); push(K_DONE, 0);
    b0 = busy_cnt;
    issue(4'd1, 4'd0, 4'd8, 4'd1, 32'd0);
    wait_idle("mm_basic");
    check("mm_basic_cycles", 64'(busy_cnt - b0), 64'd25);

    // serial W write to page 1 with a gap in in_valid
    for (int i = 0; i < 4; i++) push(K_WWE, 32'd1);
    push(K_DONE, 0);
    issue(4'd2, 4'd9, 4'd0, 4'd0, 32'd0);
    burst(5'b11011, 5);
    wait_idle("wr_w");

    for (int i = 0; i < 4; i++) push(K_XWE, 32'h5);
    push(K_DONE, 0);
    issue(4'd2, 4'd1, 4'd0, 4'd0, 32'd0);
    burst(5'b01111, 4);
    wait_idle("wr_x");

    // bulk write mid-stream, then early drain exit on y_valid[7]
    push_stream(2, 1, 3, 0, 4); push(K_XWE, 32'hB);
    push_stream(2, 1, 3, 4, 4); push(K_XWE, 32'hB); push(K_DONE, 0);
    b0 = busy_cnt;
    issue(4'd1, 4'd2, 4'd9, 4'd3, 32'd0);
    step(2); mult_clear_out = 8'h01;
    step();  mult_clear_out = 8'h00;
    check("y_valid_delay", 64'(y_valid), 64'h01);
    step(4); mult_clear_out = 8'h80;
    step();  mult_clear_out = 8'h00;
    wait_idle("mm_bulk");
    check("mm_bulk_cycles", 64'(busy_cnt - b0), 64'd10);

    push(K_ERR, 0); issue(4'd1, 4'd2, 4'd8, 4'd2, 32'd0);
    check("err_overlap_idle", 64'(busy), 64'd0);
    push(K_ERR, 0); issue(4'd1, 4'd0, 4'd0, 4'd1, 32'd0);
    check("err_wfile_idle", 64'(busy), 64'd0);
    push(K_ERR, 0); issue(4'd7, 4'd0, 4'd0, 4'd0, 32'd0);
    check("err_opcode_idle", 64'(busy), 64'd0);
    push(K_ERR, 0); issue(4'd3, 4'd2, 4'd0, 4'd0, 32'd5);
    issue(4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
    check("nop_idle", 64'(busy), 64'd0);

    // enable low for 3 cycles in STREAM
    push_stream(0, 0, 3, 0, 8); push(K_DONE, 0);
    b0 = busy_cnt;
    issue(4'd1, 4'd0, 4'd8, 4'd1, 32'd0);
    step(3);
    enable = 1'b0;
    hold = {w_idx, x_idx};
    for (int i = 0; i < 3; i++) begin
      step();
      check("frozen_idx", 64'({w_idx, x_idx}), 64'(hold));
      check("frozen_strobes", 64'({stream_en, w_we, x_we, done, err}), 64'd0);
    end
    enable = 1'b1;
    wait_idle("mm_stall");
    check("mm_stall_cycles", 64'(busy_cnt - b0), 64'd25);

    // reset mid-stream at w_idx = 5, then defaults must be back
    push(K_DONE, 0); issue(4'd3, 4'd0, 4'd0, 4'd0, 32'd7);
    push_stream(0, 0, 7, 0, 6);
    issue(4'd1, 4'd0, 4'd8, 4'd1, 32'd0);
    step(5);
    check("pre_reset_idx", 64'(w_idx), 64'd5);
    #6;
    reset = 1'b1;
    #1;
    check("reset_mid_outputs", 64'(outs), 64'd0);
    step();
    reset = 1'b0;
    step();
    check("ready_after_mid_reset", 64'(cmd_ready), 64'd1);
    push_stream(0, 0, 31, 0, 64); push(K_DONE, 0);
    b0 = busy_cnt;
    issue(4'd1, 4'd0, 4'd8, 4'd1, 32'd0);
    wait_idle("mm_default");
    check("mm_default_cycles", 64'(busy_cnt - b0), 64'd81);

    step(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
